// File: rtl/ps2_key_decoder_if.sv
// Bundle between a PS/2 line source and the key decoder: raw PS/2 lines in,
// decoded key events out.
interface ps2_key_decoder_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [9:0] key_data;
  logic       key_valid;
  logic       key_ext;

  modport master (
    output ps2_clk, ps2_data,
    input  key_data, key_valid, key_ext
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output key_data, key_valid, key_ext
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code set 2 receiver: folds E0/F0 prefixes into {brk, 1, code} events.
// Optional macro PS2_PARITY_CHECK_EN rejects frames with even parity.
module ps2_key_decoder #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input logic            clk,
  input logic            rst,
  ps2_key_decoder_if.slave bus
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_CHECK} state_t;

  state_t        r_state, w_state_nx;
  logic [1:0]    r_clk_s, r_dat_s;
  logic          r_fclk, r_fclk_d;
  logic [FW-1:0] r_fcnt;
  logic [TW-1:0] r_tcnt;
  logic [3:0]    r_bitcnt;
  logic [9:0]    r_shift;
  logic          r_ext_pend, r_brk_pend;
  logic [9:0]    r_key_data;
  logic          r_key_valid, r_key_ext;

  logic w_clk_s, w_dat_s, w_strobe, w_timeout, w_accept, w_emit;
  logic w_is_e0, w_is_f0;

  assign w_clk_s   = r_clk_s[1];
  assign w_dat_s   = r_dat_s[1];
  assign w_strobe  = r_fclk_d & ~r_fclk;
  assign w_timeout = (r_state == S_SHIFT) && (r_tcnt == TW'(TIMEOUT));
  assign w_is_e0   = (r_shift[7:0] == 8'hE0);
  assign w_is_f0   = (r_shift[7:0] == 8'hF0);

  // r_shift holds {stop, parity, data[7:0]} once CHECK is reached
`ifdef PS2_PARITY_CHECK_EN
  assign w_accept = r_shift[9] & (^r_shift[8:0]);
`else
  assign w_accept = r_shift[9];
`endif

  assign w_emit = (r_state == S_CHECK) && w_accept && !w_is_e0 && !w_is_f0;

  // Synchronisers idle high so a reset never manufactures a clock edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_s  <= 2'b11;
      r_dat_s  <= 2'b11;
      r_fclk   <= 1'b1;
      r_fclk_d <= 1'b1;
      r_fcnt   <= '0;
    end else begin
      r_clk_s  <= {r_clk_s[0], bus.ps2_clk};
      r_dat_s  <= {r_dat_s[0], bus.ps2_data};
      r_fclk_d <= r_fclk;
      if (w_clk_s == r_fclk) begin
        r_fcnt <= '0;
      end else if (r_fcnt == FW'(FILTER_LEN - 1)) begin
        r_fclk <= ~r_fclk;
        r_fcnt <= '0;
      end else begin
        r_fcnt <= r_fcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (w_strobe && !w_dat_s) w_state_nx = S_SHIFT;
      S_SHIFT: begin
        if (w_timeout)                           w_state_nx = S_IDLE;
        else if (w_strobe && r_bitcnt == 4'd9)   w_state_nx = S_CHECK;
      end
      S_CHECK: w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tcnt      <= '0;
      r_bitcnt    <= '0;
      r_shift     <= '0;
      r_ext_pend  <= 1'b0;
      r_brk_pend  <= 1'b0;
      r_key_data  <= '0;
      r_key_valid <= 1'b0;
      r_key_ext   <= 1'b0;
    end else begin
      if (r_state != S_SHIFT || w_strobe) r_tcnt <= '0;
      else if (r_tcnt != TW'(TIMEOUT))    r_tcnt <= r_tcnt + 1'b1;

      if (r_state != S_SHIFT) begin
        r_bitcnt <= '0;
      end else if (w_strobe) begin
        r_bitcnt <= r_bitcnt + 1'b1;
        r_shift  <= {w_dat_s, r_shift[9:1]};
      end

      // Rejected frames, timeouts and emitted events all drop pending prefixes
      if (w_timeout || (r_state == S_CHECK && !w_accept) || w_emit) begin
        r_ext_pend <= 1'b0;
        r_brk_pend <= 1'b0;
      end else if (r_state == S_CHECK) begin
        if (w_is_e0) r_ext_pend <= 1'b1;
        if (w_is_f0) r_brk_pend <= 1'b1;
      end

      r_key_valid <= w_emit;
      if (w_emit) begin
        r_key_data <= {r_brk_pend, 1'b1, r_shift[7:0]};
        r_key_ext  <= r_ext_pend;
      end
    end
  end

  assign bus.key_data  = r_key_data;
  assign bus.key_valid = r_key_valid;
  assign bus.key_ext   = r_key_ext;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed prefix/parity/timeout/reset cases plus
// random byte streams checked against a prefix-folding event model.
module tb_ps2_key_decoder;
  localparam int FILT = 8;
  localparam int TMO  = 500;
  localparam int HALF = 20;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  ps2_key_decoder_if bus();

  ps2_key_decoder #(.FILTER_LEN(FILT), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [9:0] ev_data[$];
  logic       ev_ext[$];
  logic [9:0] exp_data[$];
  logic       exp_ext[$];
  logic       prev_kv = 1'b0;
  bit         m_ext = 1'b0, m_brk = 1'b0;

  always @(negedge clk) begin
    if (bus.key_valid === 1'b1) begin
      n_vec++;
      assert (prev_kv === 1'b0) else begin
        n_err++;
        $error("FAIL pulse_width observed=%b expected=%b", prev_kv, 1'b0);
      end
      ev_data.push_back(bus.key_data);
      ev_ext.push_back(bus.key_ext);
    end
    prev_kv = bus.key_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_byte(input logic [7:0] c, input bit bad);
    if (bad && PAR_EN) begin
      m_ext = 1'b0; m_brk = 1'b0;
    end else if (c == 8'hE0) begin
      m_ext = 1'b1;
    end else if (c == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      exp_data.push_back({m_brk, 1'b1, c});
      exp_ext.push_back(m_ext);
      m_ext = 1'b0; m_brk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] c, input bit bad, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^c) ^ bad, c, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      bus.ps2_data = f[i];
      repeat (HALF) @(posedge clk);
      bus.ps2_clk = 1'b0;
      repeat (HALF) @(posedge clk);
      bus.ps2_clk = 1'b1;
    end
  endtask

  task automatic byte_tx(input logic [7:0] c, input bit bad);
    model_byte(c, bad);
    send_frame(c, bad, 11);
    bus.ps2_data = 1'b1;
    repeat (HALF) @(posedge clk);
  endtask

  task automatic check_events(input string tag);
    int n;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk({tag, "_count"}, ev_data.size(), exp_data.size());
    n = (ev_data.size() < exp_data.size()) ? ev_data.size() : exp_data.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_data"}, ev_data[i], exp_data[i]);
      chk({tag, "_ext"},  ev_ext[i],  exp_ext[i]);
    end
    ev_data.delete(); ev_ext.delete();
    exp_data.delete(); exp_ext.delete();
  endtask

  initial begin
    logic [7:0] c;
    logic [10:0] f72;
    int nb;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_data",  bus.key_data,  10'h000);
    chk("rst_valid", bus.key_valid, 1'b0);
    chk("rst_ext",   bus.key_ext,   1'b0);
    rst = 1'b0;
    repeat (10) @(posedge clk);

    byte_tx(8'hE0, 0); byte_tx(8'h6B, 0);
    check_events("ext_make");
    chk("ext_make_word", bus.key_data, 10'h16B);
    chk("ext_make_flag", bus.key_ext, 1'b1);

    byte_tx(8'hE0, 0); byte_tx(8'hF0, 0); byte_tx(8'h6B, 0);
    check_events("ext_break");
    chk("ext_break_word", bus.key_data, 10'h36B);

    byte_tx(8'h29, 0); byte_tx(8'hF0, 0); byte_tx(8'h29, 0);
    check_events("space");
    chk("space_word", bus.key_data, 10'h329);
    chk("space_ext", bus.key_ext, 1'b0);

    byte_tx(8'hF0, 1); byte_tx(8'h74, 0);
    check_events("parity");
    chk("parity_word", bus.key_data, PAR_EN ? 10'h174 : 10'h374);

    byte_tx(8'hE0, 0); byte_tx(8'hE0, 0); byte_tx(8'hF0, 0); byte_tx(8'h6B, 0);
    check_events("dup_prefix");
    byte_tx(8'hF0, 0); byte_tx(8'hE0, 0); byte_tx(8'h6B, 0);
    check_events("swap_prefix");
    chk("swap_prefix_word", bus.key_data, 10'h36B);

    // Break prefix pending, then a partial frame that must time out
    byte_tx(8'hF0, 0);
    send_frame(8'h75, 0, 5);
    bus.ps2_data = 1'b1;
    repeat (TMO + 10) @(posedge clk);
    m_ext = 1'b0; m_brk = 1'b0;
    byte_tx(8'h75, 0);
    check_events("timeout");
    chk("timeout_word", bus.key_data, 10'h175);

    send_frame(8'h72, 0, 6);
    f72 = {1'b1, ~^8'h72, 8'h72, 1'b0};
    bus.ps2_data = f72[6];
    repeat (HALF) @(posedge clk);
    bus.ps2_clk = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_data",  bus.key_data,  10'h000);
    chk("midrst_valid", bus.key_valid, 1'b0);
    chk("midrst_ext",   bus.key_ext,   1'b0);
    bus.ps2_clk = 1'b1; bus.ps2_data = 1'b1;
    repeat (10) @(posedge clk);
    rst = 1'b0;
    m_ext = 1'b0; m_brk = 1'b0;
    ev_data.delete(); ev_ext.delete();
    repeat (10) @(posedge clk);
    byte_tx(8'hE0, 0); byte_tx(8'h72, 0);
    check_events("after_rst");
    chk("after_rst_word", bus.key_data, 10'h172);
    chk("after_rst_ext", bus.key_ext, 1'b1);

    for (int s = 0; s < 20; s++) begin
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        case ($urandom_range(0, 3))
          0: c = 8'hE0;
          1: c = 8'hF0;
          default: begin
            c = 8'($urandom_range(0, 255));
            if (c == 8'hE0 || c == 8'hF0) c = 8'h1C;
          end
        endcase
        byte_tx(c, ($urandom_range(0, 7) == 0));
      end
      check_events("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
